// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH general-purpose registers for the
// CPU datapath. One synchronous write port and two asynchronous read ports
// feed the ALU operand paths. An optional bypass forwards in-flight write
// data to a read port that addresses the register being written.
`timescale 1ns/1ps

module register_file #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter bit WRITE_BYPASS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write_en,
    input  logic [ADDR_WIDTH-1:0] reg_write_dest,
    input  logic [DATA_WIDTH-1:0] reg_write_data,
    input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
    output logic [DATA_WIDTH-1:0] reg_read_data_1,
    input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
    output logic [DATA_WIDTH-1:0] reg_read_data_2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Next-state contents: only the addressed register takes the write data.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (reg_write_en) begin
            regs_d[reg_write_dest] = reg_write_data;
        end
    end

    // Storage; reset clears everything at once and wins over a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port 1: combinational lookup, with optional forwarding of write data.
    always_comb begin
        reg_read_data_1 = regs_q[reg_read_addr_1];
        if (WRITE_BYPASS && !rst && reg_write_en && (reg_write_dest == reg_read_addr_1)) begin
            reg_read_data_1 = reg_write_data;
        end
    end

    // Read port 2: identical to port 1, fully independent address.
    always_comb begin
        reg_read_data_2 = regs_q[reg_read_addr_2];
        if (WRITE_BYPASS && !rst && reg_write_en && (reg_write_dest == reg_read_addr_2)) begin
            reg_read_data_2 = reg_write_data;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios followed by random traffic,
// checked against an array model. Two instances share all inputs, one without
// write bypass and one with it, so both read-during-write behaviours are seen.
`timescale 1ns/1ps

module tb_register_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  dest;
    logic [15:0] wdata;
    logic [3:0]  a1, a2;
    logic [15:0] rd1, rd2, brd1, brd2;

    logic [15:0] mem [16];
    int          vec_cnt;
    int          err_cnt;

    register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_BYPASS(1'b0)) dut (
        .clk(clk), .rst(rst),
        .reg_write_en(we), .reg_write_dest(dest), .reg_write_data(wdata),
        .reg_read_addr_1(a1), .reg_read_data_1(rd1),
        .reg_read_addr_2(a2), .reg_read_data_2(rd2)
    );

    register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst(rst),
        .reg_write_en(we), .reg_write_dest(dest), .reg_write_data(wdata),
        .reg_read_addr_1(a1), .reg_read_data_1(brd1),
        .reg_read_addr_2(a2), .reg_read_data_2(brd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_plain(input logic [3:0] a);
        return rst ? 16'h0000 : mem[a];
    endfunction

    function automatic logic [15:0] model_byp(input logic [3:0] a);
        if (!rst && we && dest == a) return wdata;
        return model_plain(a);
    endfunction

    task automatic check_ports(input string tag);
        check_val({tag, " p1"},     rd1,  model_plain(a1));
        check_val({tag, " p2"},     rd2,  model_plain(a2));
        check_val({tag, " byp p1"}, brd1, model_byp(a1));
        check_val({tag, " byp p2"}, brd2, model_byp(a2));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    endtask

    // One clock edge; the model commits the write the DUT sees at that edge.
    task automatic tick();
        @(posedge clk);
        if (!rst && we) mem[dest] = wdata;
        #1;
    endtask

    task automatic sweep_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            a1 = 4'(i);
            a2 = 4'(15 - i);
            #1;
            check_ports(tag);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        clear_model();
        rst = 1'b1; we = 1'b0; dest = '0; wdata = '0; a1 = '0; a2 = '0;

        // Reset readback
        #10;
        check_ports("in reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a1 = 4'(i);
            a2 = 4'(i);
            #40;
            check_ports("reset readback");
        end

        // Write A000+i, one per clock
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; dest = 4'(i); wdata = 16'hA000 + 16'(i);
            tick();
        end
        we = 1'b0;
        sweep_all("fill");
        a1 = 4'd7; #1;
        check_val("fill lit r7", rd1, 16'hA007);

        // Write-enable gating
        we = 1'b0; dest = 4'd3; wdata = 16'hFFFF; a1 = 4'd3; a2 = 4'd3;
        repeat (4) tick();
        check_val("gated r3", rd1, 16'hA003);
        check_ports("gated");

        // Read during write, same address
        we = 1'b1; dest = 4'd5; wdata = 16'h1111;
        tick();
        we = 1'b1; dest = 4'd5; wdata = 16'h2222; a1 = 4'd5; a2 = 4'd5;
        #2;
        check_val("rdw before p1", rd1, 16'h1111);
        check_val("rdw before byp", brd2, 16'h2222);
        check_ports("rdw before");
        tick();
        we = 1'b0;
        #1;
        check_val("rdw after p2", rd2, 16'h2222);
        check_ports("rdw after");

        // Asynchronous reset between edges
        a1 = 4'd9; a2 = 4'd5;
        #1;
        rst = 1'b1;
        clear_model();
        #1;
        check_val("async rst p1", rd1, 16'h0000);
        check_val("async rst p2", rd2, 16'h0000);
        we = 1'b1; dest = 4'd9; wdata = 16'h5A5A;
        tick();
        check_ports("write in reset");
        we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        we = 1'b1; dest = 4'd15; wdata = 16'hBEEF;
        tick();
        we = 1'b0;
        sweep_all("after reset");
        a1 = 4'd15; #1;
        check_val("beef r15", rd1, 16'hBEEF);

        // Write isolation: load distinct values, then touch only reg 0
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; dest = 4'(i); wdata = 16'(($urandom & 16'hFFFF) | 16'h0100);
            tick();
        end
        we = 1'b1; dest = 4'd0; wdata = 16'h00FF;
        tick();
        we = 1'b0;
        a1 = 4'd0; #1;
        check_val("iso r0", rd1, 16'h00FF);
        sweep_all("isolation");

        // Random traffic with occasional mid-cycle reset
        for (int n = 0; n < 400; n++) begin
            we    = 1'($urandom_range(0, 1));
            dest  = 4'($urandom_range(0, 15));
            wdata = 16'($urandom);
            a1    = 4'($urandom_range(0, 15));
            a2    = ($urandom_range(0, 3) == 0) ? dest : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                clear_model();
            end else begin
                rst = 1'b0;
            end
            #2;
            check_ports("rand pre");
            tick();
        end
        rst = 1'b0;
        we  = 1'b0;
        #1;
        sweep_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
